// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I fetch slice.
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  // Sequential successor of an instruction address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    next_pc = pc + 32'd4;
  endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// One-entry {pc, instr} holding buffer used while the IF/ID register is stalled.
module rv32i_fetch_skid
  import rv32i_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic             flush,
  input  logic [WIDTH-1:0] load_pc,
  input  logic [WIDTH-1:0] load_instr,
  output logic             valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr
);

  logic             valid_r;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] instr_r;

  // Buffer state: flush beats load, load beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
      instr_r <= WIDTH'(NOP_INSTR);
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      instr_r <= load_instr;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// PC sequencing and single-outstanding instruction fetch feeding the IF/ID register.
module rv32i_fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEFAULT_RESET_VEC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_target,
  input  logic             i_trap,
  input  logic [WIDTH-1:0] i_trap_vec,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic             o_if_valid,
  output logic [WIDTH-1:0] o_if_pc,
  output logic [WIDTH-1:0] o_if_pc_plus_4,
  output logic [WIDTH-1:0] o_if_instr
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(32'd4);

  fetch_state_t     state_r, state_s;
  logic [WIDTH-1:0] pc_r, pc_s;
  logic [WIDTH-1:0] req_pc_r, req_pc_s;
  logic             drop_r, drop_s;
  logic             deliver_s;

  logic             if_valid_r;
  logic [WIDTH-1:0] if_pc_r;
  logic [WIDTH-1:0] if_pc4_r;
  logic [WIDTH-1:0] if_instr_r;

  logic             flush_s;
  logic [WIDTH-1:0] target_s;
  logic             req_s;
  logic             fire_s;
  logic             blocked_s;
  logic             skid_load_s;
  logic             skid_drain_s;
  logic             skid_valid_s;
  logic [WIDTH-1:0] skid_pc_s;
  logic [WIDTH-1:0] skid_instr_s;

  assign flush_s   = i_trap | i_redirect;
  assign target_s  = i_trap ? i_trap_vec : i_redirect_target;
  // A buffered word parks the request until the IF/ID register frees up.
  assign req_s     = (state_r == REQ) && !skid_valid_s;
  assign fire_s    = req_s && i_imem_gnt;
  assign blocked_s = if_valid_r && i_stall;

  assign skid_load_s  = deliver_s && blocked_s;
  assign skid_drain_s = !flush_s && !blocked_s && skid_valid_s;

  // Fetch FSM and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_r     <= RESET_VEC;
      req_pc_r <= RESET_VEC;
      drop_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
      drop_r   <= drop_s;
    end
  end

  // Next-state, PC selection and drop tracking for stale in-flight fetches.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    req_pc_s  = req_pc_r;
    drop_s    = drop_r;
    deliver_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_s = REQ;
        if (flush_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
      end
      REQ: begin
        if (fire_s) begin
          state_s  = RESP;
          req_pc_s = pc_r;
          drop_s   = flush_s;
        end else begin
          state_s  = REQ;
        end
        if (flush_s) begin
          pc_s = target_s;
        end else begin
          pc_s = pc_r;
        end
      end
      RESP: begin
        if (i_imem_rvalid) begin
          state_s = REQ;
          drop_s  = 1'b0;
          if (flush_s) begin
            pc_s = target_s;
          end else if (drop_r) begin
            pc_s = pc_r;
          end else begin
            pc_s      = next_pc(req_pc_r);
            deliver_s = 1'b1;
          end
        end else begin
          state_s = RESP;
          if (flush_s) begin
            pc_s   = target_s;
            drop_s = 1'b1;
          end else begin
            drop_s = drop_r;
          end
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // IF/ID register: flush > hold while blocked > skid drain > new word > consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_r <= 1'b0;
      if_pc_r    <= '0;
      if_pc4_r   <= '0;
      if_instr_r <= WIDTH'(NOP_INSTR);
    end else if (flush_s) begin
      if_valid_r <= 1'b0;
    end else if (blocked_s) begin
      if_valid_r <= if_valid_r;
    end else if (skid_valid_s) begin
      if_valid_r <= 1'b1;
      if_pc_r    <= skid_pc_s;
      if_pc4_r   <= skid_pc_s + PC_STEP;
      if_instr_r <= skid_instr_s;
    end else if (deliver_s) begin
      if_valid_r <= 1'b1;
      if_pc_r    <= req_pc_r;
      if_pc4_r   <= req_pc_r + PC_STEP;
      if_instr_r <= i_imem_rdata;
    end else begin
      if_valid_r <= 1'b0;
    end
  end

  rv32i_fetch_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load_s),
    .drain     (skid_drain_s),
    .flush     (flush_s),
    .load_pc   (req_pc_r),
    .load_instr(i_imem_rdata),
    .valid     (skid_valid_s),
    .pc        (skid_pc_s),
    .instr     (skid_instr_s)
  );

  assign o_imem_req     = req_s;
  assign o_imem_addr    = pc_r;
  assign o_if_valid     = if_valid_r;
  assign o_if_pc        = if_pc_r;
  assign o_if_pc_plus_4 = if_pc4_r;
  assign o_if_instr     = if_instr_r;

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Directed bench for rv32i_fetch_ctrl: sequential fetch, stall/skid, redirects, trap priority, reset.
module tb_rv32i_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_target;
  logic        i_trap;
  logic [31:0] i_trap_vec;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc_plus_4;
  logic [31:0] o_if_instr;

  int errs;
  int checks;

  rv32i_fetch_ctrl #(
    .WIDTH    (32),
    .RESET_VEC(32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (i_stall),
    .i_redirect       (i_redirect),
    .i_redirect_target(i_redirect_target),
    .i_trap           (i_trap),
    .i_trap_vec       (i_trap_vec),
    .o_imem_req       (o_imem_req),
    .o_imem_addr      (o_imem_addr),
    .i_imem_gnt       (i_imem_gnt),
    .i_imem_rvalid    (i_imem_rvalid),
    .i_imem_rdata     (i_imem_rdata),
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_pc_plus_4   (o_if_pc_plus_4),
    .o_if_instr       (o_if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst_n = 1'b0;
    i_stall = 1'b0;
    i_redirect = 1'b0;
    i_redirect_target = 32'h0;
    i_trap = 1'b0;
    i_trap_vec = 32'h0;
    i_imem_gnt = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = 32'h0;

    tick();
    tick();
    chk("rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_if_valid}, 32'd0);
    chk("rst_pc", o_if_pc, 32'h0);
    chk("rst_pc4", o_if_pc_plus_4, 32'h0);
    chk("rst_instr", o_if_instr, 32'h0000_0013);

    // Test 1: sequential fetch, zero-latency memory
    rst_n = 1'b1;
    i_imem_gnt = 1'b1;
    i_imem_rvalid = 1'b1;
    chk("boot_req", {31'd0, o_imem_req}, 32'd0);
    tick();
    chk("t1_req0", {31'd0, o_imem_req}, 32'd1);
    chk("t1_addr0", o_imem_addr, 32'h0);
    tick();
    chk("t1_resp_req", {31'd0, o_imem_req}, 32'd0);
    i_imem_rdata = 32'h1111_0013;
    tick();
    chk("t1_v0", {31'd0, o_if_valid}, 32'd1);
    chk("t1_pc0", o_if_pc, 32'h0);
    chk("t1_pc4_0", o_if_pc_plus_4, 32'h4);
    chk("t1_instr0", o_if_instr, 32'h1111_0013);
    chk("t1_addr1", o_imem_addr, 32'h4);
    tick();
    chk("t1_gap", {31'd0, o_if_valid}, 32'd0);
    i_imem_rdata = 32'h2222_0013;
    tick();
    chk("t1_pc1", o_if_pc, 32'h4);
    chk("t1_pc4_1", o_if_pc_plus_4, 32'h8);
    chk("t1_v1", {31'd0, o_if_valid}, 32'd1);
    chk("t1_addr2", o_imem_addr, 32'h8);
    tick();
    i_imem_rdata = 32'h3333_0013;
    tick();
    chk("t1_pc2", o_if_pc, 32'h8);
    chk("t1_pc4_2", o_if_pc_plus_4, 32'hC);
    chk("t1_instr2", o_if_instr, 32'h3333_0013);

    // Test 2: stall holds outputs, next word goes to skid
    i_stall = 1'b1;
    tick();
    chk("t2_hold_v", {31'd0, o_if_valid}, 32'd1);
    chk("t2_hold_pc", o_if_pc, 32'h8);
    i_imem_rdata = 32'h4444_0013;
    tick();
    chk("t2_hold_pc_b", o_if_pc, 32'h8);
    chk("t2_hold_instr", o_if_instr, 32'h3333_0013);
    chk("t2_noreq", {31'd0, o_imem_req}, 32'd0);
    chk("t2_addr", o_imem_addr, 32'h10);
    tick();
    chk("t2_noreq_b", {31'd0, o_imem_req}, 32'd0);
    chk("t2_hold_pc4", o_if_pc_plus_4, 32'hC);
    i_stall = 1'b0;
    tick();
    chk("t2_drain_v", {31'd0, o_if_valid}, 32'd1);
    chk("t2_drain_pc", o_if_pc, 32'hC);
    chk("t2_drain_pc4", o_if_pc_plus_4, 32'h10);
    chk("t2_drain_instr", o_if_instr, 32'h4444_0013);
    chk("t2_req_back", {31'd0, o_imem_req}, 32'd1);
    tick();
    chk("t2_consumed", {31'd0, o_if_valid}, 32'd0);

    // Test 3: redirect in RESP before rvalid
    i_imem_rvalid = 1'b0;
    i_redirect = 1'b1;
    i_redirect_target = 32'h100;
    tick();
    i_redirect = 1'b0;
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hBAD0_0001;
    chk("t3_wait_req", {31'd0, o_imem_req}, 32'd0);
    tick();
    chk("t3_dropped", {31'd0, o_if_valid}, 32'd0);
    chk("t3_req", {31'd0, o_imem_req}, 32'd1);
    chk("t3_addr", o_imem_addr, 32'h100);
    tick();
    i_imem_rdata = 32'h5555_0013;
    tick();
    chk("t3_v", {31'd0, o_if_valid}, 32'd1);
    chk("t3_pc", o_if_pc, 32'h100);
    chk("t3_instr", o_if_instr, 32'h5555_0013);

    // Test 4: trap beats redirect
    i_imem_gnt = 1'b0;
    i_trap = 1'b1;
    i_trap_vec = 32'h200;
    i_redirect = 1'b1;
    i_redirect_target = 32'h100;
    tick();
    i_trap = 1'b0;
    i_redirect = 1'b0;
    chk("t4_addr", o_imem_addr, 32'h200);
    chk("t4_req", {31'd0, o_imem_req}, 32'd1);
    chk("t4_flush", {31'd0, o_if_valid}, 32'd0);

    // Test 5a: redirect concurrent with gnt
    i_imem_gnt = 1'b1;
    i_redirect = 1'b1;
    i_redirect_target = 32'h300;
    tick();
    i_redirect = 1'b0;
    i_imem_rdata = 32'hDEAD_0002;
    chk("t5a_resp", {31'd0, o_imem_req}, 32'd0);
    tick();
    chk("t5a_dropped", {31'd0, o_if_valid}, 32'd0);
    chk("t5a_addr", o_imem_addr, 32'h300);
    tick();
    i_imem_rdata = 32'h6666_0013;
    tick();
    chk("t5a_pc", o_if_pc, 32'h300);
    chk("t5a_pc4", o_if_pc_plus_4, 32'h304);
    chk("t5a_instr", o_if_instr, 32'h6666_0013);

    // Test 5b: redirect concurrent with rvalid
    tick();
    i_redirect = 1'b1;
    i_redirect_target = 32'h400;
    i_imem_rdata = 32'hBAD0_0003;
    tick();
    i_redirect = 1'b0;
    chk("t5b_discard", {31'd0, o_if_valid}, 32'd0);
    chk("t5b_addr", o_imem_addr, 32'h400);
    tick();
    i_imem_rdata = 32'h7777_0013;
    tick();
    chk("t5b_v", {31'd0, o_if_valid}, 32'd1);
    chk("t5b_pc", o_if_pc, 32'h400);
    chk("t5b_instr", o_if_instr, 32'h7777_0013);

    // Test 6: reset while a response is outstanding
    tick();
    i_imem_rvalid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", {31'd0, o_if_valid}, 32'd0);
    chk("t6_rst_req", {31'd0, o_imem_req}, 32'd0);
    chk("t6_rst_instr", o_if_instr, 32'h0000_0013);
    rst_n = 1'b1;
    i_imem_rvalid = 1'b1;
    i_imem_rdata = 32'hBAD0_0004;
    tick();
    chk("t6_nodeliver", {31'd0, o_if_valid}, 32'd0);
    chk("t6_req", {31'd0, o_imem_req}, 32'd1);
    chk("t6_addr", o_imem_addr, 32'h0);

    // PC wrap at the top of the address space
    i_imem_gnt = 1'b0;
    i_redirect = 1'b1;
    i_redirect_target = 32'hFFFF_FFFC;
    tick();
    i_redirect = 1'b0;
    i_imem_gnt = 1'b1;
    chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    i_imem_rdata = 32'h8888_0013;
    tick();
    chk("wrap_pc", o_if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", o_if_pc_plus_4, 32'h0);
    chk("wrap_next_addr", o_imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
